tx_fifo_reader: RTL and testbench

TX_FIFO_READER -- requirements
Module: tx_fifo_reader

---
 rtl/tx_fifo_reader.sv | 168 ++++++++++++++++
 tb/tb_tx_fifo_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo_reader
// Brief    : Drains BURST_LEN-word packets from a FIFO onto a ready/valid stream.
// Revision : 1.0 - initial release
// ============================================================================
module tx_fifo_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 10,
    parameter int BURST_LEN   = 256
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic [DEPTH_WIDTH:0]  fifo_rd_water_level,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_first,
    output logic                  m_last,
    output logic [15:0]           pkt_cnt,
    output logic                  busy
);

    localparam int                   c_cnt_w       = $clog2(BURST_LEN);
    localparam logic [c_cnt_w-1:0]   c_last_idx    = c_cnt_w'(BURST_LEN - 1);
    localparam logic [DEPTH_WIDTH:0] c_burst_level = (DEPTH_WIDTH + 1)'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_cnt_w-1:0]    r_issue_cnt;
    logic [15:0]           r_pkt_cnt;

    logic                  r_inflight;
    logic                  r_inflight_first;
    logic                  r_inflight_last;

    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [1:0]            r_buf_first;
    logic [1:0]            r_buf_last;
    logic [1:0]            r_occ;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_fill;
    logic                  w_issue_first;
    logic                  w_issue_last;

    // Slots already committed after this edge: buffered + arriving - leaving.
    assign w_pop         = m_valid && m_ready;
    assign w_push        = r_inflight;
    assign w_fill        = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en    = (r_state == S_BURST) && !fifo_rd_empty && (w_fill < 3'd2);
    assign w_issue_first = (r_issue_cnt == '0);
    assign w_issue_last  = (r_issue_cnt == c_last_idx);

    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_buf_data[0];
    assign m_first = m_valid && r_buf_first[0];
    assign m_last  = m_valid && r_buf_last[0];
    assign pkt_cnt = r_pkt_cnt;
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_pkt_cnt   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_issue_cnt <= '0;
                    if (fifo_rd_water_level >= c_burst_level) begin
                        r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (fifo_rd_en) begin
                        r_issue_cnt <= r_issue_cnt + c_cnt_w'(1);
                        if (w_issue_last) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_pop && m_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_pop && m_last) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    // Packet tags are captured at issue time and ride along with the read data.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_inflight       <= 1'b0;
            r_inflight_first <= 1'b0;
            r_inflight_last  <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (fifo_rd_en) begin
                r_inflight_first <= w_issue_first;
                r_inflight_last  <= w_issue_last;
            end
        end
    end

    // Two-entry shift buffer; slot 0 is always the head.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_occ         <= 2'd0;
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_first   <= 2'b00;
            r_buf_last    <= 2'b00;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf_data[0]  <= fifo_rd_data;
                        r_buf_first[0] <= r_inflight_first;
                        r_buf_last[0]  <= r_inflight_last;
                    end else begin
                        r_buf_data[1]  <= fifo_rd_data;
                        r_buf_first[1] <= r_inflight_first;
                        r_buf_last[1]  <= r_inflight_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf_data[0]  <= r_buf_data[1];
                    r_buf_first[0] <= r_buf_first[1];
                    r_buf_last[0]  <= r_buf_last[1];
                    r_occ          <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf_data[0]  <= fifo_rd_data;
                        r_buf_first[0] <= r_inflight_first;
                        r_buf_last[0]  <= r_inflight_last;
                    end else begin
                        r_buf_data[0]  <= r_buf_data[1];
                        r_buf_first[0] <= r_buf_first[1];
                        r_buf_last[0]  <= r_buf_last[1];
                        r_buf_data[1]  <= fifo_rd_data;
                        r_buf_first[1] <= r_inflight_first;
                        r_buf_last[1]  <= r_inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_fifo_reader
// Brief    : Self-checking bench for tx_fifo_reader (BURST_LEN 4 and 256).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_fifo_reader;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int BL_A = 4;
    localparam int BL_B = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: BURST_LEN 4
    logic          rst_n_a = 1'b0;
    logic          rd_en_a;
    logic [DW-1:0] rd_data_a = '0;
    logic          empty_a = 1'b1;
    logic [AW:0]   level_a = '0;
    logic          m_valid_a;
    logic          m_ready_a = 1'b1;
    logic [DW-1:0] m_data_a;
    logic          m_first_a, m_last_a, busy_a;
    logic [15:0]   pkt_cnt_a;

    // Instance B: BURST_LEN 256
    logic          rst_n_b = 1'b0;
    logic          rd_en_b;
    logic [DW-1:0] rd_data_b = '0;
    logic          empty_b = 1'b0;
    logic [AW:0]   level_b = '0;
    logic          m_valid_b;
    logic          m_ready_b = 1'b1;
    logic [DW-1:0] m_data_b;
    logic          m_first_b, m_last_b, busy_b;
    logic [15:0]   pkt_cnt_b;

    tx_fifo_reader #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .BURST_LEN(BL_A)) dut_a (
        .rd_clk(clk), .rd_rst_n(rst_n_a),
        .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data_a), .fifo_rd_empty(empty_a),
        .fifo_rd_water_level(level_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
        .m_first(m_first_a), .m_last(m_last_a), .pkt_cnt(pkt_cnt_a), .busy(busy_a)
    );

    tx_fifo_reader #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .BURST_LEN(BL_B)) dut_b (
        .rd_clk(clk), .rd_rst_n(rst_n_b),
        .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data_b), .fifo_rd_empty(empty_b),
        .fifo_rd_water_level(level_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
        .m_first(m_first_b), .m_last(m_last_b), .pkt_cnt(pkt_cnt_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // Reference model for A: FIFO contents, words read but not yet delivered,
    // and the position of the next beat within its packet.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] outst_q[$];
    logic          force_empty = 1'b0;
    int            beat_idx = 0;
    int            issued_in_pkt = 0;
    logic [15:0]   pkt_model = 16'd0;
    logic          pend_v = 1'b0;
    logic [DW-1:0] pend_d = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_first = 1'b0, prev_last = 1'b0;

    task automatic push_word();
        logic [DW-1:0] w;
        w = $urandom;
        fifo_q.push_back(w);
    endtask

    // Called at a negedge with m_ready_a / force_empty already chosen.
    task automatic step_a();
        logic [DW-1:0] w;
        rd_data_a = pend_v ? pend_d : DW'($urandom);
        level_a   = (AW+1)'(fifo_q.size());
        empty_a   = force_empty || (fifo_q.size() == 0);
        #1;
        check("pkt_cnt", 64'(pkt_cnt_a), 64'(pkt_model));
        if (prev_stall) begin
            check("hold_valid", 64'(m_valid_a), 64'd1);
            check("hold_data",  64'(m_data_a),  64'(prev_data));
            check("hold_first", 64'(m_first_a), 64'(prev_first));
            check("hold_last",  64'(m_last_a),  64'(prev_last));
        end
        pend_v = 1'b0;
        if (rd_en_a) begin
            check("rd_en_while_empty", 64'(empty_a), 64'd0);
            check("rd_en_past_burst", 64'(issued_in_pkt < BL_A), 64'd1);
            if (issued_in_pkt == 0) check("start_level", 64'(level_a >= BL_A), 64'd1);
            issued_in_pkt++;
            if (fifo_q.size() != 0) begin
                w = fifo_q.pop_front();
                pend_d = w;
                pend_v = 1'b1;
                outst_q.push_back(w);
            end
        end
        if (m_valid_a && m_ready_a) begin
            if (outst_q.size() == 0) begin
                check("beat_without_read", 64'd1, 64'd0);
            end else begin
                w = outst_q.pop_front();
                check("beat_data",  64'(m_data_a),  64'(w));
                check("beat_first", 64'(m_first_a), 64'(beat_idx == 0));
                check("beat_last",  64'(m_last_a),  64'(beat_idx == BL_A - 1));
                if (beat_idx == BL_A - 1) begin
                    beat_idx = 0;
                    issued_in_pkt = 0;
                    pkt_model = pkt_model + 16'd1;
                end else begin
                    beat_idx++;
                end
            end
        end
        if (rd_en_a) check("outstanding_le_2", 64'(outst_q.size() <= 2), 64'd1);
        prev_stall = m_valid_a && !m_ready_a;
        prev_data  = m_data_a;
        prev_first = m_first_a;
        prev_last  = m_last_a;
        @(negedge clk);
    endtask

    // Finish whatever packet is open, then leave A idle with an empty FIFO.
    task automatic drain_a(input string tag);
        bit done;
        done = 1'b0;
        force_empty = 1'b0;
        m_ready_a = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            if (!busy_a && outst_q.size() == 0 && beat_idx == 0 && fifo_q.size() < BL_A) begin
                done = 1'b1;
            end else begin
                if (fifo_q.size() == 0 && (busy_a || beat_idx != 0)) push_word();
                step_a();
            end
        end
        if (!done) check({tag, "_drain_timeout"}, 64'd0, 64'd1);
        fifo_q.delete();
    endtask

    typedef struct {
        logic [AW:0]   level;
        logic [DW-1:0] rd_data;
        logic          exp_rd_en;
        logic          exp_busy;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_first;
        logic          exp_last;
        logic [15:0]   exp_pkt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit            ok;
        logic [15:0]   pkt_exp;
        int            reads_b, rd_cycles, first_rd, last_rd, beats_b, first_beat, last_beat;
        logic          pend_b;
        int            pend_idx;

        // One BURST_LEN=4 packet with m_ready high; data fed directly.
        vecs[0] = '{11'd3, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd0};
        vecs[1] = '{11'd3, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd0};
        vecs[2] = '{11'd4, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd0};
        vecs[3] = '{11'd4, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 16'd0};
        vecs[4] = '{11'd3, 32'hA000_0000, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 16'd0};
        vecs[5] = '{11'd2, 32'hA000_0001, 1'b1, 1'b1, 1'b1, 32'hA000_0000, 1'b1, 1'b0, 16'd0};
        vecs[6] = '{11'd1, 32'hA000_0002, 1'b1, 1'b1, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 16'd0};
        vecs[7] = '{11'd0, 32'hA000_0003, 1'b0, 1'b1, 1'b1, 32'hA000_0002, 1'b0, 1'b0, 16'd0};
        vecs[8] = '{11'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'hA000_0003, 1'b0, 1'b1, 16'd0};
        vecs[9] = '{11'd0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 16'd1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rd_en",   64'(rd_en_a),   64'd0);
        check("rst_valid",   64'(m_valid_a), 64'd0);
        check("rst_first",   64'(m_first_a), 64'd0);
        check("rst_last",    64'(m_last_a),  64'd0);
        check("rst_busy",    64'(busy_a),    64'd0);
        check("rst_data",    64'(m_data_a),  64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt_a), 64'd0);

        rst_n_a = 1'b1;
        m_ready_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            level_a   = vecs[i].level;
            empty_a   = (vecs[i].level == '0);
            rd_data_a = vecs[i].rd_data;
            #1;
            check($sformatf("vec%0d_rd_en", i), 64'(rd_en_a),   64'(vecs[i].exp_rd_en));
            check($sformatf("vec%0d_busy", i),  64'(busy_a),    64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_valid", i), 64'(m_valid_a), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_first", i), 64'(m_first_a), 64'(vecs[i].exp_first));
            check($sformatf("vec%0d_last", i),  64'(m_last_a),  64'(vecs[i].exp_last));
            check($sformatf("vec%0d_pkt", i),   64'(pkt_cnt_a), 64'(vecs[i].exp_pkt));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_data", i), 64'(m_data_a), 64'(vecs[i].exp_data));
            @(negedge clk);
        end
        pkt_model = 16'd1;

        // Random backpressure, empty glitches and bursty FIFO fill
        for (int c = 0; c < 3000; c++) begin
            m_ready_a   = 1'($urandom_range(0, 1));
            force_empty = ($urandom_range(0, 9) == 0);
            if (fifo_q.size() < 12 && $urandom_range(0, 1) == 1) push_word();
            step_a();
        end
        drain_a("random");

        // Empty held high for 5 cycles in the middle of a burst
        pkt_exp = pkt_model + 16'd1;
        repeat (BL_A) push_word();
        m_ready_a = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            step_a();
            if (issued_in_pkt == 2) ok = 1'b1;
        end
        check("pause_reach_mid_burst", 64'(ok), 64'd1);
        force_empty = 1'b1;
        repeat (5) step_a();
        check("pause_no_issue", 64'(issued_in_pkt), 64'd2);
        drain_a("pause");
        check("pause_pkt_complete", 64'(pkt_cnt_a), 64'(pkt_exp));

        // Reset with two beats buffered
        repeat (8) push_word();
        m_ready_a = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            step_a();
            if (outst_q.size() == 2 && !pend_v && beat_idx == 0) ok = 1'b1;
        end
        check("mid_reset_two_buffered", 64'(ok), 64'd1);
        check("mid_reset_pre_valid", 64'(m_valid_a), 64'd1);
        rst_n_a = 1'b0;
        #1;
        check("mid_reset_rd_en", 64'(rd_en_a),   64'd0);
        check("mid_reset_valid", 64'(m_valid_a), 64'd0);
        check("mid_reset_first", 64'(m_first_a), 64'd0);
        check("mid_reset_last",  64'(m_last_a),  64'd0);
        check("mid_reset_busy",  64'(busy_a),    64'd0);
        check("mid_reset_data",  64'(m_data_a),  64'd0);
        check("mid_reset_pkt",   64'(pkt_cnt_a), 64'd0);
        outst_q.delete();
        pend_v = 1'b0;
        beat_idx = 0;
        issued_in_pkt = 0;
        pkt_model = 16'd0;
        prev_stall = 1'b0;
        @(negedge clk);
        check("mid_reset_hold_valid", 64'(m_valid_a), 64'd0);
        check("mid_reset_hold_busy",  64'(busy_a),    64'd0);
        rst_n_a = 1'b1;
        m_ready_a = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            step_a();
            if (beat_idx != 0) ok = 1'b1;
        end
        check("post_reset_first_beat", 64'(ok), 64'd1);
        drain_a("post_reset");
        check("post_reset_pkt", 64'(pkt_cnt_a), 64'd1);

        // Packet counter wrap
        force dut_a.r_pkt_cnt = 16'hFFFF;
        pkt_model = 16'hFFFF;
        repeat (BL_A) push_word();
        m_ready_a = 1'b1;
        step_a();
        release dut_a.r_pkt_cnt;
        drain_a("wrap");
        check("pkt_wrap", 64'(pkt_cnt_a), 64'h0000);

        // BURST_LEN=256 throughput: level 300, m_ready held high
        reads_b = 0; rd_cycles = 0; first_rd = -1; last_rd = -1;
        beats_b = 0; first_beat = -1; last_beat = -1;
        pend_b = 1'b0; pend_idx = 0;
        m_ready_b = 1'b1;
        empty_b = 1'b0;
        level_b = 11'd300;
        rst_n_b = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rd_data_b = pend_b ? DW'(pend_idx) : DW'($urandom);
            level_b   = (AW+1)'(300 - reads_b);
            #1;
            pend_b = 1'b0;
            if (rd_en_b) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                rd_cycles++;
                pend_b = 1'b1;
                pend_idx = reads_b;
                reads_b++;
            end
            if (m_valid_b) begin
                if (first_beat < 0) first_beat = c;
                last_beat = c;
                if (beats_b < BL_B) begin
                    check("b_beat_data",  64'(m_data_b),  64'(beats_b));
                    check("b_beat_first", 64'(m_first_b), 64'(beats_b == 0));
                    check("b_beat_last",  64'(m_last_b),  64'(beats_b == BL_B - 1));
                end
                beats_b++;
            end
            @(negedge clk);
        end
        check("b_rd_en_cycles",    64'(rd_cycles), 64'(BL_B));
        check("b_rd_en_contig",    64'(last_rd - first_rd + 1), 64'(BL_B));
        check("b_beats",           64'(beats_b), 64'(BL_B));
        check("b_no_valid_gap",    64'(last_beat - first_beat + 1), 64'(BL_B));
        check("b_first_latency",   64'(first_beat - first_rd), 64'd2);
        check("b_pkt_cnt",         64'(pkt_cnt_b), 64'd1);
        check("b_idle_after",      64'(busy_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
